dac_serial_writer: RTL and testbench

Serial transmitter for the heater-side 8-bit DAC (AD5300-style: 16-bit frame, SYNC framing, data sampled on the falling edge of the serial clock). It is the write-direction counterpart of the ADC serial reader. It takes an 8-bit level plus power-down mode through a valid/ready handshake, then shifts one frame out MSB first. Sits between the control loop and the DAC pins.

---
 rtl/dac_pkg.sv | 28 ++
 rtl/half_period_timer.sv | 31 +++
 rtl/dac_serial_writer.sv | 112 +++++++++++
 tb/tb_dac_serial_writer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the heater DAC serial writer: state encoding, frame layout, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } dac_state_t;

    localparam int FRAME_BITS   = 16;
    localparam int PD_MSB       = 13;
    localparam int DATA_MSB     = 11;
    localparam int DEFAULT_HALF = 2;

    // Assemble a DAC frame: two zero control bits, pd, level, four don't-care zeros.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] pd, input logic [7:0] level);
        logic [FRAME_BITS-1:0] f;
        f                = '0;
        f[PD_MSB -: 2]   = pd;
        f[DATA_MSB -: 8] = level;
        return f;
    endfunction

endpackage

// File: rtl/half_period_timer.sv
// Free-running divider: tick is high for one clock every HALF clocks; load restarts the period.
// Latency: first tick HALF-1 clocks after the load edge, i.e. HALF clocks into the new period.
// Backpressure: none; the timer always runs.
module half_period_timer import dac_pkg::*; #(
    parameter int HALF = DEFAULT_HALF
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int CW = $clog2(HALF) + 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count 0..HALF-1 and wrap; load realigns the period to the accept edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_serial_writer.sv
// Shifts one 16-bit AD5300-style frame ({00, pd, level, 0000}) MSB first on clockDA/nSYNC/DIN.
// Latency: done pulses 35*HALF clocks after the accept edge.
// Backpressure: ready only in IDLE; valid while busy is dropped, not queued.
module dac_serial_writer import dac_pkg::*; #(
    parameter int HALF       = DEFAULT_HALF,
    parameter int FRAME_BITS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] level,
    input  logic [1:0] pd,
    input  logic       valid,
    output logic       ready,
    output logic       done,
    output logic       clockDA,
    output logic       nSYNC,
    output logic       DIN
);

    dac_state_t            state;
    logic                  phase_low;
    logic [4:0]            bitcnt;
    // Bits still to be sent after the one currently on DIN.
    logic [FRAME_BITS-2:0] shreg;
    logic [FRAME_BITS-1:0] frame_in;
    logic                  accept;
    logic                  tick;

    assign ready    = (state == IDLE);
    assign accept   = valid && ready;
    assign frame_in = build_frame(pd, level);

    half_period_timer #(.HALF(HALF)) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .tick  (tick)
    );

    // Frame sequencer: every phase lasts one timer period; all pin outputs are registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase_low <= 1'b0;
            bitcnt    <= '0;
            shreg     <= '0;
            done      <= 1'b0;
            clockDA   <= 1'b1;
            nSYNC     <= 1'b1;
            DIN       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg     <= frame_in[FRAME_BITS-2:0];
                        DIN       <= frame_in[FRAME_BITS-1];
                        nSYNC     <= 1'b0;
                        clockDA   <= 1'b1;
                        bitcnt    <= '0;
                        phase_low <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    // SETUP already shows bit 15 with clockDA high, same as a SHIFT high phase.
                    if (tick) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!phase_low) begin
                            // Falling edge: the DAC samples DIN here.
                            clockDA   <= 1'b0;
                            phase_low <= 1'b1;
                        end else begin
                            // Rising edge: DIN moves on only here.
                            clockDA   <= 1'b1;
                            phase_low <= 1'b0;
                            if (bitcnt == 5'(FRAME_BITS - 1)) begin
                                DIN   <= 1'b0;
                                state <= HOLD;
                            end else begin
                                bitcnt <= bitcnt + 5'd1;
                                DIN    <= shreg[FRAME_BITS-2];
                                shreg  <= {shreg[FRAME_BITS-3:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        nSYNC <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    // Minimum SYNC-high time before the next frame may start.
                    if (tick) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_serial_writer.sv
// Self-checking bench: two DUTs (HALF=2 and HALF=1), a pin-level frame decoder and a frame model.
// Latency: checks done at 35*HALF clocks after accept.
// Backpressure: checks that valid while busy is ignored.
module tb_dac_serial_writer;

    logic       clock = 1'b0;
    logic       reset;
    logic       valid_s [2];
    logic [7:0] level_s [2];
    logic [1:0] pd_s    [2];
    logic       ready_w [2];
    logic       done_w  [2];
    logic       cda_w   [2];
    logic       ns_w    [2];
    logic       din_w   [2];

    always #5 clock = ~clock;

    dac_serial_writer #(.HALF(2), .FRAME_BITS(16)) u_h2 (
        .clock(clock), .reset(reset), .level(level_s[0]), .pd(pd_s[0]), .valid(valid_s[0]),
        .ready(ready_w[0]), .done(done_w[0]), .clockDA(cda_w[0]), .nSYNC(ns_w[0]), .DIN(din_w[0])
    );

    dac_serial_writer #(.HALF(1), .FRAME_BITS(16)) u_h1 (
        .clock(clock), .reset(reset), .level(level_s[1]), .pd(pd_s[1]), .valid(valid_s[1]),
        .ready(ready_w[1]), .done(done_w[1]), .clockDA(cda_w[1]), .nSYNC(ns_w[1]), .DIN(din_w[1])
    );

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Pin decoder state (one slot per DUT).
    logic        prev_cda [2];
    logic        prev_ns  [2];
    int          falls    [2];
    int          bad      [2];
    int          done_cnt [2];
    int          done_cyc [2];
    int          hi_run   [2];
    int          last_hi  [2];
    logic [15:0] cap      [2];
    logic [20:0] fq0 [$];
    logic [20:0] fq1 [$];

    typedef struct {
        int         inst;
        logic [7:0] level;
        logic [1:0] pd;
        logic [15:0] exp;
    } vec_t;

    function automatic int half_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Reference: frame = 00 | pd | level | 0000, read MSB first.
    function automatic logic [15:0] model_frame(input logic [7:0] lv, input logic [1:0] p);
        return 16'((int'(p) * 4096) + (int'(lv) * 16));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Decode frames off the pins: DIN at every clockDA fall, framed by nSYNC.
    initial begin
        for (int i = 0; i < 2; i++) begin
            prev_cda[i] = 1'b1; prev_ns[i] = 1'b1; falls[i] = 0; bad[i] = 0;
            done_cnt[i] = 0; done_cyc[i] = 0; hi_run[i] = 0; last_hi[i] = 0; cap[i] = '0;
        end
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                if (ns_w[i] && prev_ns[i] && (cda_w[i] !== prev_cda[i])) bad[i]++;
                if (prev_ns[i] && !ns_w[i]) begin
                    cap[i] = '0; falls[i] = 0; last_hi[i] = hi_run[i];
                end
                if (!ns_w[i] && prev_cda[i] && !cda_w[i]) begin
                    cap[i] = {cap[i][14:0], din_w[i]}; falls[i]++;
                end
                if (!prev_ns[i] && ns_w[i]) begin
                    if (i == 0) fq0.push_back({5'(falls[i]), cap[i]});
                    else        fq1.push_back({5'(falls[i]), cap[i]});
                end
                hi_run[i] = ns_w[i] ? hi_run[i] + 1 : 0;
                if (done_w[i]) begin done_cnt[i]++; done_cyc[i] = cyc; end
                prev_cda[i] = cda_w[i];
                prev_ns[i]  = ns_w[i];
            end
        end
    end

    task automatic clear_q(input int i);
        if (i == 0) fq0.delete(); else fq1.delete();
    endtask

    task automatic pop_frame(input int i, input string nm, output logic [20:0] r, output bit ok);
        r = '0;
        ok = (i == 0) ? (fq0.size() > 0) : (fq1.size() > 0);
        chk({nm, "_present"}, 32'(ok), 32'd1);
        if (ok) r = (i == 0) ? fq0.pop_front() : fq1.pop_front();
    endtask

    task automatic wait_done(input int i, input int d0, input string nm, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clock); #1;
            if (done_cnt[i] != d0) begin ok = 1'b1; break; end
        end
        chk({nm, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic run_frame(input int i, input logic [7:0] lv, input logic [1:0] p,
                             input logic [15:0] exp, input string nm);
        int t0, d0, b0;
        bit ok;
        logic [20:0] r;
        clear_q(i);
        d0 = done_cnt[i]; b0 = bad[i];
        @(posedge clock); #1;
        level_s[i] = lv; pd_s[i] = p; valid_s[i] = 1'b1; t0 = cyc + 1;
        @(posedge clock); #1;
        valid_s[i] = 1'b0; level_s[i] = ~lv; pd_s[i] = ~p;
        wait_done(i, d0, nm, ok);
        if (ok) begin
            chk({nm, "_latency"}, 32'(done_cyc[i] - t0), 32'(35 * half_of(i)));
            pop_frame(i, nm, r, ok);
            chk({nm, "_frame"}, 32'(r[15:0]), 32'(exp));
            chk({nm, "_falls"}, 32'(r[20:16]), 32'd16);
            repeat (3) @(posedge clock);
            #1;
            chk({nm, "_one_done"}, 32'(done_cnt[i] - d0), 32'd1);
            chk({nm, "_no_idle_edges"}, 32'(bad[i] - b0), 32'd0);
        end
    endtask

    vec_t tbl [4];

    initial begin
        int idle_bad, d0, t0, t1;
        bit ok;
        logic [20:0] r;
        logic [7:0] rl;
        logic [1:0] rp;
        int ri;

        tbl[0] = '{0, 8'hA5, 2'b00, 16'h0A50};
        tbl[1] = '{1, 8'hFF, 2'b11, 16'h3FF0};
        tbl[2] = '{0, 8'h00, 2'b10, 16'h2000};
        tbl[3] = '{1, 8'h3C, 2'b01, 16'h13C0};

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin valid_s[i] = 1'b0; level_s[i] = '0; pd_s[i] = '0; end
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(ready_w[i]), 32'd1);
            chk("rst_done",  32'(done_w[i]),  32'd0);
            chk("rst_clockDA", 32'(cda_w[i]), 32'd1);
            chk("rst_nSYNC", 32'(ns_w[i]),    32'd1);
            chk("rst_DIN",   32'(din_w[i]),   32'd0);
        end
        @(posedge clock); #1;
        reset = 1'b0;

        // Idle with valid low: pins stay at their idle levels.
        idle_bad = 0;
        repeat (200) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++)
                if (!(ns_w[i] === 1'b1 && cda_w[i] === 1'b1 && din_w[i] === 1'b0 &&
                      done_w[i] === 1'b0 && ready_w[i] === 1'b1)) idle_bad++;
        end
        chk("idle_stable", 32'(idle_bad), 32'd0);

        // Vector table.
        for (int v = 0; v < 4; v++)
            run_frame(tbl[v].inst, tbl[v].level, tbl[v].pd, tbl[v].exp, $sformatf("vec%0d", v));

        // Back-to-back with valid held and level changed mid-frame.
        clear_q(0);
        d0 = done_cnt[0];
        @(posedge clock); #1;
        level_s[0] = 8'h01; pd_s[0] = 2'b00; valid_s[0] = 1'b1; t0 = cyc + 1;
        @(posedge clock); #1;
        level_s[0] = 8'h80;
        wait_done(0, d0, "b2b_first", ok);
        if (ok) begin
            t1 = done_cyc[0] + 1;
            valid_s[0] = 1'b0;
            chk("b2b_latency1", 32'(done_cyc[0] - t0), 32'd70);
            wait_done(0, d0 + 1, "b2b_second", ok);
            if (ok) begin
                chk("b2b_latency2", 32'(done_cyc[0] - t1), 32'd70);
                chk("b2b_sync_gap_ge_half", 32'(last_hi[0] >= 2), 32'd1);
                pop_frame(0, "b2b_f1", r, ok);
                chk("b2b_frame1", 32'(r[15:0]), 32'h0010);
                pop_frame(0, "b2b_f2", r, ok);
                chk("b2b_frame2", 32'(r[15:0]), 32'h0800);
            end
        end
        valid_s[0] = 1'b0;
        repeat (5) @(posedge clock);

        // valid pulsed while busy is ignored.
        clear_q(0);
        d0 = done_cnt[0];
        @(posedge clock); #1;
        level_s[0] = 8'h42; pd_s[0] = 2'b00; valid_s[0] = 1'b1;
        @(posedge clock); #1;
        valid_s[0] = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        level_s[0] = 8'hE7; valid_s[0] = 1'b1;
        @(posedge clock); #1;
        valid_s[0] = 1'b0;
        wait_done(0, d0, "busy", ok);
        repeat (100) @(posedge clock);
        #1;
        chk("busy_one_done", 32'(done_cnt[0] - d0), 32'd1);
        chk("busy_one_frame", 32'(fq0.size()), 32'd1);
        pop_frame(0, "busy", r, ok);
        chk("busy_frame", 32'(r[15:0]), 32'(model_frame(8'h42, 2'b00)));

        // Reset during bit 7: immediate idle pins, no done, then a clean frame.
        clear_q(0);
        d0 = done_cnt[0];
        @(posedge clock); #1;
        level_s[0] = 8'hC3; pd_s[0] = 2'b01; valid_s[0] = 1'b1;
        @(posedge clock); #1;
        valid_s[0] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clock);
            if (falls[0] == 7) begin ok = 1'b1; break; end
        end
        chk("abort_reached_bit7", 32'(ok), 32'd1);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("abort_nSYNC",   32'(ns_w[0]),    32'd1);
        chk("abort_clockDA", 32'(cda_w[0]),   32'd1);
        chk("abort_DIN",     32'(din_w[0]),   32'd0);
        #17 reset = 1'b0;
        @(posedge clock); #1;
        chk("abort_ready", 32'(ready_w[0]), 32'd1);
        repeat (100) @(posedge clock);
        #1;
        chk("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
        pop_frame(0, "abort", r, ok);
        chk("abort_falls", 32'(r[20:16]), 32'd7);
        run_frame(0, 8'h5A, 2'b01, 16'h15A0, "after_abort");

        // Randomised frames against the model.
        for (int n = 0; n < 8; n++) begin
            ri = int'($urandom_range(0, 1));
            rl = 8'($urandom);
            rp = 2'($urandom);
            run_frame(ri, rl, rp, model_frame(rl, rp), $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
